// File: rtl/butterfly_injector_if.sv
// Request and fabric-side signal bundle for one butterfly_injector instance.
//
// Handshake rule for both channels (s_* request side, m_* fabric side):
// a transfer happens on a rising clk edge where valid && ready are both 1;
// once valid is raised it stays high, with data stable, until that transfer.
// The injector itself honours this on m_*; the requester must honour it on s_*.
interface butterfly_injector_if #(
  parameter int PW = 32,
  parameter int AW = 3
);
  logic          s_valid;
  logic          s_ready;
  logic [PW-1:0] s_data;
  logic [AW-1:0] s_dest;
  logic          s_bcast;

  logic             m_valid;
  logic             m_ready;
  logic [PW+AW-1:0] m_data;

  // Debug view of the output FSM: 1 while a broadcast is being expanded,
  // plus the current broadcast destination index.
  logic          dbg_state;
  logic [AW-1:0] dbg_idx;

  // Environment side: issues requests, acts as the fabric input port.
  modport master (
    output s_valid, s_data, s_dest, s_bcast, m_ready,
    input  s_ready, m_valid, m_data, dbg_state, dbg_idx
  );

  // Injector side.
  modport slave (
    input  s_valid, s_data, s_dest, s_bcast, m_ready,
    output s_ready, m_valid, m_data, dbg_state, dbg_idx
  );
endinterface

// File: rtl/butterfly_injector.sv
// Source-side flit builder for one input of the 8-port butterfly fabric.
// Buffers {bcast, dest, payload} requests, prepends the routing header
// {dest} (MSB steers stage 0) and expands broadcasts into N flits with
// headers 0..N-1 in ascending order.
module butterfly_injector #(
  parameter int PW    = 32,
  parameter int N     = 8,
  parameter int AW    = $clog2(N),
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  butterfly_injector_if.slave bus,
  output logic [15:0]       flit_cnt
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  typedef enum logic {ST_UNI, ST_BCAST} state_e;

  // Request storage, one field per array so the head is read directly.
  logic [PW-1:0] mem_payload [DEPTH];
  logic [AW-1:0] mem_dest    [DEPTH];
  logic          mem_bcast   [DEPTH];

  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            empty, full, push, pop, handshake;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          in_bcast;
  logic [AW-1:0] hdr;

  assign empty     = (count == CW'(0));
  assign full      = (count == CW'(DEPTH));
  // Ready comes only from the registered count: a pop in the same cycle
  // does not open a slot for a push while full.
  assign push      = bus.s_valid && !full;
  assign handshake = bus.m_valid && bus.m_ready;

  assign bus.s_ready   = !full;
  assign bus.m_valid   = !empty;
  assign bus.m_data    = empty ? '0 : {hdr, mem_payload[rd_ptr]};
  assign bus.dbg_state = (state_q == ST_BCAST);
  assign bus.dbg_idx   = idx_q;

  // Output FSM: pick the header and decide when the head request retires.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pop      = 1'b0;
    // A broadcast head is handled as broadcast from its first cycle,
    // before the state register has moved to ST_BCAST.
    in_bcast = (state_q == ST_BCAST) || mem_bcast[rd_ptr];
    hdr      = in_bcast ? idx_q : mem_dest[rd_ptr];
    if (handshake) begin
      if (in_bcast) begin
        if (idx_q == AW'(N - 1)) begin
          pop     = 1'b1;
          idx_d   = '0;
          state_d = ST_UNI;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_BCAST;
        end
      end else begin
        pop = 1'b1;
      end
    end
  end

  // FSM state and broadcast index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_UNI;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Request FIFO: storage, wrapping pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_payload[i] <= '0;
        mem_dest[i]    <= '0;
        mem_bcast[i]   <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_payload[wr_ptr] <= bus.s_data;
        mem_dest[wr_ptr]    <= bus.s_dest;
        mem_bcast[wr_ptr]   <= bus.s_bcast;
        wr_ptr              <= wr_ptr + PTRW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Count of flits taken by the fabric; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flit_cnt <= '0;
    end else if (handshake) begin
      flit_cnt <= flit_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_butterfly_injector.sv
// Directed bench for butterfly_injector: flit-level scoreboard plus
// hand-computed expectations for reset, unicast, broadcast, backpressure,
// stalled broadcast, counter wrap and reset in the middle of a broadcast.
module tb_butterfly_injector;
  localparam int PW    = 32;
  localparam int N     = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] flit_cnt;

  butterfly_injector_if #(.PW(PW), .AW(AW)) bus ();

  butterfly_injector #(.PW(PW), .N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .flit_cnt (flit_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Each expected flit carries a "last flit of its request" flag on top.
  logic [PW+AW:0] exp_q[$];
  int             occ;          // requests still owning flits in exp_q
  logic [15:0]    cnt_model;
  bit             chk_en;
  int             n_checks;
  int             n_pass;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Compare process: mid-cycle, check outputs against the model, then
  // account for whatever transfers the next rising edge will perform.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", bus.m_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("m_data", bus.m_data, exp_q[0][PW+AW-1:0]);
      check("s_ready", bus.s_ready, occ < DEPTH);
      check("flit_cnt", flit_cnt, cnt_model);
      if (!rst_n) begin
        exp_q.delete();
        occ       = 0;
        cnt_model = '0;
      end else begin
        if (bus.m_valid && bus.m_ready && exp_q.size() != 0) begin
          if (exp_q[0][PW+AW]) occ--;
          void'(exp_q.pop_front());
          cnt_model = cnt_model + 16'd1;
        end
        if (bus.s_valid && bus.s_ready) begin
          if (bus.s_bcast) begin
            for (int i = 0; i < N; i++)
              exp_q.push_back({(i == N - 1), AW'(i), bus.s_data});
          end else begin
            exp_q.push_back({1'b1, bus.s_dest, bus.s_data});
          end
          occ++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [PW-1:0] d, input logic [AW-1:0] dst, input logic bc);
    bit ok;
    ok          = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_dest  = dst;
    bus.s_bcast = bc;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", ok, 1'b1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.m_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", done, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [PW-1:0] bp_data [5];
  logic [AW-1:0] bp_dest [5];

  initial begin
    n_checks = 0; n_pass = 0; occ = 0; cnt_model = '0; chk_en = 1'b0;
    rst_n = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 32'h11112222; bus.s_dest = 3'd6; bus.s_bcast = 1'b0;
    bus.m_ready = 1'b0;
    bp_data = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005};
    bp_dest = '{3'd7, 3'd0, 3'd3, 3'd4, 3'd1};

    // Reset held 3 cycles with a request pending.
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_m_valid", bus.m_valid, 1'b0);
      check("rst_s_ready", bus.s_ready, 1'b1);
      check("rst_flit_cnt", flit_cnt, 16'd0);
      check("rst_m_data", bus.m_data, 35'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; bus.s_valid = 1'b0; bus.m_ready = 1'b1;
    @(negedge clk);
    check("rst_nothing_queued", bus.m_valid, 1'b0);
    @(posedge clk); #1;

    // Unicast, one cycle latency, single-cycle valid.
    send(32'hDEADBEEF, 3'd5, 1'b0);
    @(negedge clk);
    check("uni_valid", bus.m_valid, 1'b1);
    check("uni_data", bus.m_data, 35'h5_DEADBEEF);
    @(negedge clk);
    check("uni_valid_drop", bus.m_valid, 1'b0);
    check("uni_cnt", flit_cnt, 16'd1);
    @(posedge clk); #1;

    // Broadcast: headers 0..7 on consecutive cycles.
    send(32'h12345678, 3'd2, 1'b1);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("bc_flit", bus.m_data, {AW'(i), 32'h12345678});
    end
    @(negedge clk);
    check("bc_done", bus.m_valid, 1'b0);
    check("bc_cnt", flit_cnt, 16'd9);
    @(posedge clk); #1;

    // Backpressure: fill the FIFO, fifth request waits.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(bp_data[i], bp_dest[i], 1'b0);
    @(negedge clk);
    check("full_s_ready", bus.s_ready, 1'b0);
    @(posedge clk); #1;
    bus.s_valid = 1'b1; bus.s_data = bp_data[4]; bus.s_dest = bp_dest[4]; bus.s_bcast = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("full_hold_ready", bus.s_ready, 1'b0);
      check("full_hold_data", bus.m_data, {3'd7, 32'hA0000001});
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("release_ready_still0", bus.s_ready, 1'b0);
    @(negedge clk);
    check("release_ready_rise", bus.s_ready, 1'b1);
    check("release_second", bus.m_data, {3'd0, 32'hA0000002});
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    drain();
    check("bp_cnt", flit_cnt, 16'd14);

    // Broadcast stalled at idx 3, followed by a unicast to port 2.
    send(32'hCCCC0000, 3'd0, 1'b1);
    send(32'h0000D002, 3'd2, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_hdr", bus.m_data[PW+AW-1:PW], 3'd3);
      check("stall_valid", bus.m_valid, 1'b1);
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("resume_hdr3", bus.m_data[PW+AW-1:PW], 3'd3);
    @(negedge clk);
    check("resume_hdr4", bus.m_data[PW+AW-1:PW], 3'd4);
    drain();
    check("stall_cnt", flit_cnt, 16'd23);

    // Counter wrap: 8189 broadcasts bring the count to 0xFFFF.
    for (int j = 0; j < 8189; j++) send(32'h0BAD0000 + j, 3'd0, 1'b1);
    drain();
    check("cnt_ffff", flit_cnt, 16'hFFFF);
    send(32'hCAFE0001, 3'd1, 1'b0);
    drain();
    check("cnt_wrap", flit_cnt, 16'h0000);

    // Reset while a broadcast shows idx 4 and a unicast is queued.
    send(32'h55AA55AA, 3'd0, 1'b1);
    send(32'h0000E006, 3'd6, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_hdr4", bus.m_data[PW+AW-1:PW], 3'd4);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_valid", bus.m_valid, 1'b0);
    check("mid_rst_ready", bus.s_ready, 1'b1);
    check("mid_rst_cnt", flit_cnt, 16'd0);
    check("mid_rst_idx", bus.dbg_idx, 3'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_empty", bus.m_valid, 1'b0);
    @(posedge clk); #1;
    send(32'h00000077, 3'd5, 1'b1);
    @(negedge clk);
    check("post_rst_idx0", bus.m_data, {3'd0, 32'h00000077});
    drain();
    check("post_rst_cnt", flit_cnt, 16'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/butterfly_injector.md
# butterfly_injector

Per-port source-side flit builder for the 8-port butterfly switch fabric. Accepts a 32-bit payload plus destination port index, buffers it, prepends the 3-bit routing header the fabric stages consume, and drives one fabric input port with a valid/ready handshake. It also expands broadcast requests into one flit per destination, in ascending port order. One instance sits in front of each fabric input.

## Interface
- PW, 32, payload width
- N, 8, number of fabric ports (power of two)
- AW, $clog2(N) = 3, routing header width
- DEPTH, 4, request FIFO entries (power of two, ≥2)
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- s_valid  input  1  request valid
- s_ready  output  1  request ready
- s_data  input  PW  payload
- s_dest  input  AW  destination port index
- s_bcast  input  1  1 = send payload to all N ports; s_dest ignored
- m_valid  output  1  flit valid toward fabric input
- m_ready  input  1  fabric ready
- m_data  output  PW+AW  flit = {dest[AW-1:0], payload}
- flit_cnt  output  16  count of flits accepted by the fabric; wraps

## Operation
- Header encoding: m_data[PW+AW-1] = dest[2] selects upper/lower half at stage 0; m_data[PW+AW-2] = dest[1] at stage 1; m_data[PW+AW-3] = dest[0] at stage 2. Flit arrives at fabric output o_data[dest].
- Request FIFO: DEPTH entries of {bcast, dest, payload}. Push when s_valid && s_ready. s_ready = !full (registered count; no pass-through when full, even if a pop occurs the same cycle).
- Output FSM, two states:
  - UNI: head entry with bcast=0 → m_valid=1, m_data={head.dest, head.payload}; pop on m_valid && m_ready. Head with bcast=1 → behave as BCAST with idx=0 this cycle.
  - BCAST: m_data={idx, head.payload}; on handshake: if idx==N-1 pop, idx←0, go UNI; else idx←idx+1, stay.
- idx is AW bits, only changes on handshake; while m_ready=0, m_data and m_valid hold stable (AXI-style: valid never drops without handshake).
- m_valid = FIFO not empty.
- flit_cnt increments by 1 on every m_valid && m_ready, wraps 0xFFFF→0.
- Simultaneous push and pop: both performed; count unchanged.
- Push while empty: entry not visible on m_valid until next cycle.

## Timing
- Reset (rst_n low at a rising edge): FIFO empty, pointers 0, state UNI, idx 0, flit_cnt 0. Outputs after reset: m_valid=0, m_data=0 (head storage cleared), s_ready=1, flit_cnt=0.
- Reset mid-broadcast or mid-stall: all queued requests and partial broadcasts discarded; no flit emitted in the cycle after reset.
- Latency: request accepted at edge t → m_valid=1 in cycle t+1 (empty FIFO, unicast).
- Throughput: one flit per cycle with m_ready held 1; broadcast occupies N consecutive handshake cycles for one request.
- s_ready falls the cycle after the DEPTH-th push without pop; rises the cycle after the first pop from full.
- Pointers wrap modulo DEPTH; full/empty from (DEPTH+1)-state occupancy counter.

## Test plan
- Reset: hold rst_n=0 3 cycles with s_valid=1 → m_valid=0, s_ready=1, flit_cnt=0, m_data=0; nothing enqueued.
- Unicast: push payload 0xDEADBEEF dest 5, m_ready=1 → next cycle m_data=35'h5_DEADBEEF, m_valid=1 for exactly 1 cycle, flit_cnt=1.
- Broadcast: push 0x12345678 bcast=1, m_ready=1 → 8 consecutive flits with headers 0..7, same payload, then m_valid=0; flit_cnt=8.
- Backpressure/full: m_ready=0, push 5 requests back-to-back → 4 accepted, s_ready=0 from cycle after 4th; m_data stable throughout; release m_ready → flits out in order, s_ready=1 one cycle after first pop.
- Stall mid-broadcast: broadcast, drop m_ready at idx=3 for 5 cycles → m_data header stays 3, resumes at 4; following unicast (dest 2) emitted after idx 7.
- Counter wrap and reset mid-op: preload 65535 handshakes then one more → flit_cnt=0; assert rst_n=0 at broadcast idx=4 → next cycle m_valid=0, idx=0, FIFO empty.
